// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture controller: default geometry
// and the controller state encoding.
package wave_pkg;

    localparam int DEF_DATA_W  = 12;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_CAP_LEN = 1024;
    localparam int DEF_AUTO_TO = 4096;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_READY     = 2'd3
    } cap_state_t;

endpackage

// File: rtl/trig_detect.sv
// Trigger detector: rising-level comparator against the previous valid sample,
// plus a saturating auto-trigger counter of untriggered valid samples.
module trig_detect
    import wave_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int AUTO_TO = DEF_AUTO_TO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              active,
    input  logic              trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              trig
);

    localparam int CNT_W = $clog2(AUTO_TO + 1);

    logic [DATA_W-1:0] prev_sample;
    logic              prev_valid;
    logic [CNT_W-1:0]  quiet_cnt;
    logic              level_cross;
    logic              auto_fire;

    // clear wins so the first sample after arming can never form a rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sample <= '0;
            prev_valid  <= 1'b0;
            quiet_cnt   <= '0;
        end else if (clear) begin
            prev_valid  <= 1'b0;
            quiet_cnt   <= '0;
        end else if (active && sample_valid) begin
            prev_sample <= sample_in;
            prev_valid  <= 1'b1;
            if (quiet_cnt != CNT_W'(AUTO_TO))
                quiet_cnt <= quiet_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        level_cross = prev_valid && (prev_sample < trig_level) && (sample_in >= trig_level);
        auto_fire   = (quiet_cnt == CNT_W'(AUTO_TO));
        trig        = active && sample_valid && (!trig_mode || level_cross || auto_fire);
    end

endmodule

// File: rtl/wave_capture_ctrl.sv
// Double-buffered waveform capture: waits for a trigger, fills one RAM bank
// with CAP_LEN samples, then hands it to the display on the next frame_start.
module wave_capture_ctrl
    import wave_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CAP_LEN = DEF_CAP_LEN,
    parameter int AUTO_TO = DEF_AUTO_TO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              frame_start,
    output logic              ram_wr_en,
    output logic              ram_wr_bank,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              disp_bank,
    output logic              busy,
    output logic              capture_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CAP_LEN - 1);

    cap_state_t        state;
    cap_state_t        state_next;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_cnt_next;
    logic              wr_en_next;
    logic [ADDR_W-1:0] wr_addr_next;
    logic [DATA_W-1:0] wr_data_next;
    logic              swap;
    logic              trig;
    logic              trig_clear;
    logic              trig_active;

    assign trig_active = enable && (state == ST_WAIT_TRIG);

    trig_detect #(
        .DATA_W  (DATA_W),
        .AUTO_TO (AUTO_TO)
    ) u_trig (
        .clk          (clk),
        .rst          (rst),
        .clear        (trig_clear),
        .active       (trig_active),
        .trig_mode    (trig_mode),
        .trig_level   (trig_level),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .trig         (trig)
    );

    // enable low overrides everything, so an abort never writes or swaps
    always_comb begin
        state_next    = state;
        addr_cnt_next = addr_cnt;
        wr_en_next    = 1'b0;
        wr_addr_next  = ram_wr_addr;
        wr_data_next  = ram_wr_data;
        swap          = 1'b0;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_WAIT_TRIG;
                ST_WAIT_TRIG: begin
                    if (trig) begin
                        wr_en_next    = 1'b1;
                        wr_addr_next  = '0;
                        wr_data_next  = sample_in;
                        addr_cnt_next = ADDR_W'(1);
                        state_next    = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = addr_cnt;
                        wr_data_next = sample_in;
                        if (addr_cnt == LAST_ADDR)
                            state_next = ST_READY;
                        else
                            addr_cnt_next = addr_cnt + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    if (frame_start) begin
                        swap       = 1'b1;
                        state_next = ST_WAIT_TRIG;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
        trig_clear = (state_next == ST_WAIT_TRIG) && (state != ST_WAIT_TRIG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr_cnt     <= '0;
            ram_wr_en    <= 1'b0;
            ram_wr_addr  <= '0;
            ram_wr_data  <= '0;
            disp_bank    <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            state        <= state_next;
            addr_cnt     <= addr_cnt_next;
            ram_wr_en    <= wr_en_next;
            ram_wr_addr  <= wr_addr_next;
            ram_wr_data  <= wr_data_next;
            disp_bank    <= disp_bank ^ swap;
            capture_done <= swap;
        end
    end

    assign ram_wr_bank = ~disp_bank;
    assign busy        = (state != ST_IDLE);

endmodule

// File: doc/wave_capture_ctrl.md
WAVE_CAPTURE_CTRL -- requirements
Module: wave_capture_ctrl

Interface
REQ-001 Parameter DATA_W, default 12: sample width in bits, equal to the waveform RAM data width.
REQ-002 Parameter ADDR_W, default 10: waveform RAM address width within one bank.
REQ-003 Parameter CAP_LEN, default 1024: samples per capture, in the range 2..2**ADDR_W.
REQ-004 Parameter AUTO_TO, default 4096: valid-sample count without a trigger before the block forces one.
REQ-005 clk  in  1  sole clock, shared with the display read path.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 enable  in  1  arms capture; low aborts.
REQ-008 trig_mode  in  1  0 = free-run, 1 = rising-level trigger.
REQ-009 trig_level  in  DATA_W  trigger threshold, unsigned.
REQ-010 sample_in  in  DATA_W  ADC/DDS sample.
REQ-011 sample_valid  in  1  sample_in qualifier, one-cycle strobe.
REQ-012 frame_start  in  1  one-cycle pulse at start of each display frame.
REQ-013 ram_wr_en  out  1  RAM write strobe.
REQ-014 ram_wr_bank  out  1  bank being written; always equals ~disp_bank.
REQ-015 ram_wr_addr  out  ADDR_W  RAM write address within the bank.
REQ-016 ram_wr_data  out  DATA_W  RAM write data.
REQ-017 disp_bank  out  1  bank the display reader SHALL use.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 capture_done  out  1  one-cycle pulse on each bank swap.

Function
REQ-020 The block SHALL implement states IDLE, WAIT_TRIG, CAPTURE and READY.
REQ-021 IDLE: enable high -> WAIT_TRIG on the next cycle.
REQ-022 WAIT_TRIG, trig_mode 0: the first valid sample SHALL be the trigger.
REQ-023 WAIT_TRIG, trig_mode 1: a valid sample SHALL be the trigger when the previous valid sample < trig_level and the current sample >= trig_level.
REQ-024 The previous-sample register SHALL update only on sample_valid and SHALL be invalid after reset and on entry to WAIT_TRIG, so the first valid sample after either event can never trigger in trig_mode 1.
REQ-025 After AUTO_TO valid samples in WAIT_TRIG without a trigger, the next valid sample SHALL be the trigger.
REQ-026 The trigger sample SHALL be written at address 0 and the state SHALL become CAPTURE.
REQ-027 In CAPTURE, each valid sample SHALL be written at consecutive addresses.
REQ-028 After address CAP_LEN-1 is written, the state SHALL become READY.
REQ-029 RAM write outputs SHALL be registered: ram_wr_en, ram_wr_addr and ram_wr_data are valid exactly 1 cycle after the accepted sample_valid.
REQ-030 ram_wr_en SHALL be low whenever no sample is written.
REQ-031 READY: on frame_start, disp_bank SHALL toggle, capture_done SHALL pulse in the same registered cycle, and the state SHALL become WAIT_TRIG.
REQ-032 A frame_start in any state other than READY SHALL be ignored, including one coincident with the final CAPTURE write.
REQ-033 While in READY, valid samples SHALL be discarded.
REQ-034 enable low in any state SHALL force IDLE on the next cycle, discarding any partial capture.
REQ-035 An aborting enable low SHALL leave disp_bank unchanged and SHALL suppress ram_wr_en from that cycle onward.
REQ-036 enable low coincident with frame_start in READY SHALL abort without swapping.
REQ-037 The write address SHALL never wrap within a capture.
REQ-038 The auto-trigger counter SHALL saturate, and SHALL clear on entry to WAIT_TRIG.

Reset
REQ-039 Asserting rst SHALL immediately force state IDLE and ram_wr_en, ram_wr_bank... all outputs to these values: ram_wr_en 0, ram_wr_addr 0, ram_wr_data 0, disp_bank 0, busy 0, capture_done 0; ram_wr_bank SHALL reset to 1.
REQ-040 Reset SHALL clear the auto-trigger counter and the previous-sample valid flag.

Structure
REQ-041 Package wave_pkg SHALL hold the state enum, DATA_W/ADDR_W defaults and the CAP_LEN/AUTO_TO defaults.
REQ-042 The trigger comparator, previous-sample register and auto-trigger counter SHALL form sub-module trig_detect, which outputs a one-cycle trig pulse.

Verification
REQ-043 Bench: trig_mode 1, level 2048, ramp 2000..2100 step 10 -> first write addr 0 data 2050, bank 1.
REQ-044 Bench: free-run, capture 1024 samples, frame_start -> capture_done pulse, disp_bank 0->1, next capture writes bank 0.
REQ-045 Bench: trig_mode 1 with constant input 100 -> auto-trigger on valid sample AUTO_TO+1.
REQ-046 Bench: frame_start coincident with the write at addr 1023 -> no swap; swap on the following frame_start.
REQ-047 Bench: enable low at addr 500 -> IDLE next cycle, ram_wr_en 0 from that cycle, disp_bank unchanged; re-arm restarts at addr 0.
REQ-048 Bench: rst asserted mid-CAPTURE -> all outputs at reset values without waiting for a clock edge.
